// File: rtl/ga_host_ctrl_pkg.sv
// ga_pkg: shared constants and types for the graphics-accelerator host
// controller.
//   - Default datapath geometry: word width and lanes per beat.
//   - Accelerator command addresses.
//   - Command opcodes and host FSM states.
//   - op_addr(): maps an opcode to the address that starts it.
package ga_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANES  = 4;

  // Command addresses on the accelerator bus. IDLE_ADDR is what the bus
  // carries whenever no command is being issued.
  localparam logic [31:0] MATRIX_ADDR = 32'd0;
  localparam logic [31:0] VRT_ADDR    = 32'd1;
  localparam logic [31:0] RSLT_ADDR   = 32'd2;
  localparam logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_VERTEX = 2'd1,
    OP_READ   = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SEND,
    COMMIT,
    READ,
    RESP
  } host_state_t;

  typedef logic [DEF_DATA_W-1:0]           word_t;
  typedef logic [DEF_LANES*DEF_DATA_W-1:0] beat_t;

  // The opcode value doubles as the accelerator command address.
  function automatic logic [31:0] op_addr(input op_t op);
    case (op)
      OP_LOAD:   op_addr = MATRIX_ADDR;
      OP_VERTEX: op_addr = VRT_ADDR;
      OP_READ:   op_addr = RSLT_ADDR;
      default:   op_addr = IDLE_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/ga_host_ctrl_if.sv
// ga_host_ctrl_if: bundles the three channels of the host controller.
//   Command channel  : cmd_valid, cmd_ready, cmd_op, cmd_data
//                      (LANES*LANES words).
//   Response channel : rsp_valid, rsp_ready, rsp_data
//                      (LANES*LANES words).
//   Status           : done, err (one-cycle pulses).
//   Accelerator bus  : ga_addr, ga_data_in, ga_data_out, ga_rdy.
// The master modport is the controller; the slave modport is the system
// side together with the accelerator.
interface ga_host_ctrl_if
  import ga_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
);

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [1:0]                      cmd_op;
  logic [LANES*LANES*DATA_W-1:0]   cmd_data;

  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [LANES*LANES*DATA_W-1:0]   rsp_data;

  logic                            done;
  logic                            err;

  logic [31:0]                     ga_addr;
  logic [LANES*DATA_W-1:0]         ga_data_in;
  logic [LANES*DATA_W-1:0]         ga_data_out;
  logic                            ga_rdy;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, ga_data_out, ga_rdy,
    output cmd_ready, rsp_valid, rsp_data, done, err, ga_addr, ga_data_in
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, ga_data_out, ga_rdy,
    input  cmd_ready, rsp_valid, rsp_data, done, err, ga_addr, ga_data_in
  );

endinterface

// File: rtl/ga_host_ctrl.sv
// ga_host_ctrl: command sequencer and sole master of the graphics
// accelerator's addr/data/rdy bus.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - ga_host_ctrl_if.master
//            command in   : cmd_valid/cmd_ready/cmd_op/cmd_data
//            response out : rsp_valid/rsp_ready/rsp_data
//            status       : done, err
//            accelerator  : ga_addr, ga_data_in, ga_data_out, ga_rdy
//
// Operation:
//   - A command is accepted in IDLE.
//   - The command address is issued once the accelerator reports idle.
//   - LANES payload beats are streamed (load and vertex).
//   - LANES result beats are collected (vertex and read).
//   - The result is held as one response until the consumer takes it.
module ga_host_ctrl
  import ga_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic           clk,
  input  logic           rst,
  ga_host_ctrl_if.master bus
);

  localparam int BEAT_W  = LANES * DATA_W;
  localparam int BLOCK_W = LANES * BEAT_W;
  localparam int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LANES - 1);

  host_state_t         state_reg;
  op_t                 op_reg;
  logic [BLOCK_W-1:0]  cmd_data_reg;
  logic [IDX_W-1:0]    beat_reg;
  logic [BEAT_W-1:0]   rsp_beat_reg [LANES];
  logic                rsp_valid_reg;
  logic                done_reg;
  logic                err_reg;

  logic [BEAT_W-1:0]   cmd_beat [LANES];
  wire  [BLOCK_W-1:0]  rsp_data_w;
  logic [31:0]         ga_addr_c;
  logic [BEAT_W-1:0]   ga_data_in_c;
  logic                last_beat;
  logic                proto_err;

  assign last_beat = (beat_reg == LAST_BEAT);

  // The accelerator is busy from the cycle after it sees a command address
  // until its write-back or read-out completes. Seeing it idle inside that
  // window means both ends have lost step with each other.
  assign proto_err = bus.ga_rdy &&
                     ((state_reg == SEND) || (state_reg == COMMIT) ||
                      (state_reg == READ));

  // Beat k of a block occupies words LANES*k .. LANES*k+LANES-1.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_beat
    assign cmd_beat[gi]                        = cmd_data_reg[gi*BEAT_W +: BEAT_W];
    assign rsp_data_w[gi*BEAT_W +: BEAT_W]     = rsp_beat_reg[gi];
  end

  // The accelerator bus is decoded from registered state. In ISSUE the
  // address is additionally gated by ga_rdy, so the command appears only in
  // the cycle the accelerator can take it.
  always_comb begin
    ga_addr_c    = IDLE_ADDR;
    ga_data_in_c = '0;
    case (state_reg)
      ISSUE: begin
        if (bus.ga_rdy) ga_addr_c = op_addr(op_reg);
      end
      SEND: begin
        ga_data_in_c = cmd_beat[beat_reg];
        // The vertex read is chained onto the last payload beat. It is
        // suppressed on a protocol error so that no read starts on an
        // accelerator that is already out of step.
        if (last_beat && (op_reg == OP_VERTEX) && !bus.ga_rdy)
          ga_addr_c = RSLT_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= OP_LOAD;
      cmd_data_reg  <= '0;
      beat_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      for (int i = 0; i < LANES; i++) rsp_beat_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_reg       <= op_t'(bus.cmd_op);
            cmd_data_reg <= bus.cmd_data;
            // A reserved op is consumed but only reported; the accelerator
            // never sees it.
            if (op_t'(bus.cmd_op) == OP_RSVD) err_reg   <= 1'b1;
            else                              state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.ga_rdy) begin
            beat_reg  <= '0;
            state_reg <= (op_reg == OP_READ) ? READ : SEND;
          end
        end
        SEND: begin
          if (proto_err) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else if (last_beat) begin
            beat_reg  <= '0;
            state_reg <= (op_reg == OP_VERTEX) ? READ : COMMIT;
          end else begin
            beat_reg  <= beat_reg + IDX_W'(1);
          end
        end
        COMMIT: begin
          if (proto_err) err_reg  <= 1'b1;
          else           done_reg <= 1'b1;
          state_reg <= IDLE;
        end
        READ: begin
          if (proto_err) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            rsp_beat_reg[beat_reg] <= bus.ga_data_out;
            if (last_beat) begin
              beat_reg      <= '0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              beat_reg      <= beat_reg + IDX_W'(1);
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_data   = rsp_data_w;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.ga_addr    = ga_addr_c;
  assign bus.ga_data_in = ga_data_in_c;

endmodule

// File: tb/tb_ga_host_ctrl.sv
// tb_ga_host_ctrl: directed bench for ga_host_ctrl.
// The bench plays both the command source and the accelerator, driving
// ga_rdy/ga_data_out cycle by cycle.
module tb_ga_host_ctrl;
  import ga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ga_host_ctrl_if bus_if ();

  ga_host_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Load payload: words 1..16.
  localparam logic [127:0] LB0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] LB1 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] LB2 = 128'h0000000C_0000000B_0000000A_00000009;
  localparam logic [127:0] LB3 = 128'h00000010_0000000F_0000000E_0000000D;

  // Vertex payload.
  localparam logic [127:0] VB0 = 128'h10000003_10000002_10000001_10000000;
  localparam logic [127:0] VB1 = 128'h10000007_10000006_10000005_10000004;
  localparam logic [127:0] VB2 = 128'h1000000B_1000000A_10000009_10000008;
  localparam logic [127:0] VB3 = 128'h1000000F_1000000E_1000000D_1000000C;

  // Accelerator result beats.
  localparam logic [127:0] RA = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] RB = 128'hB0000003_B0000002_B0000001_B0000000;
  localparam logic [127:0] RC = 128'hC0000003_C0000002_C0000001_C0000000;
  localparam logic [127:0] RD = 128'hD0000003_D0000002_D0000001_D0000000;
  localparam logic [127:0] E0 = 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D;
  localparam logic [127:0] E1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] E2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] E3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [127:0] JUNK = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current (IDLE) cycle; returns in cycle T0.
  task automatic accept(input logic [1:0] op, input logic [511:0] data,
                        input logic rdy);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_data  = data;
    bus_if.ga_rdy    = rdy;
    #2;
    check("cmd_ready_at_accept", bus_if.cmd_ready, 1'b1);
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus_if.rsp_valid, 1'b0);
    check({tag, "_rsp_data"},  bus_if.rsp_data, '0);
    check({tag, "_done"},      bus_if.done, 1'b0);
    check({tag, "_err"},       bus_if.err, 1'b0);
    check({tag, "_ga_addr"},   bus_if.ga_addr, IDLE_ADDR);
    check({tag, "_ga_data"},   bus_if.ga_data_in, '0);
    check({tag, "_cmd_ready"}, bus_if.cmd_ready, 1'b1);
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_op      = 2'd0;
    bus_if.cmd_data    = '0;
    bus_if.rsp_ready   = 1'b0;
    bus_if.ga_data_out = '0;
    bus_if.ga_rdy      = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    // ---------------- read-only right after reset ----------------
    accept(2'd2, '0, 1'b1);
    #2;
    check("rd_addr_T0", bus_if.ga_addr, 32'd2);
    for (int t = 1; t <= 4; t++) begin
      tick();
      bus_if.ga_rdy      = 1'b0;
      bus_if.ga_data_out = '0;
      #2;
      check("rd_addr_busy", bus_if.ga_addr, IDLE_ADDR);
    end
    tick();                                   // T5
    #2;
    check("rd_rsp_valid_T5", bus_if.rsp_valid, 1'b1);
    check("rd_rsp_data",     bus_if.rsp_data, '0);
    check("rd_no_done_yet",  bus_if.done, 1'b0);
    bus_if.rsp_ready = 1'b1;
    tick();                                   // T6
    bus_if.rsp_ready = 1'b0;
    bus_if.ga_rdy    = 1'b1;
    #2;
    check("rd_rsp_dropped", bus_if.rsp_valid, 1'b0);
    check("rd_done",        bus_if.done, 1'b1);
    tick();
    #2;
    check("rd_done_once",   bus_if.done, 1'b0);
    $display("txn read-only: checks so far %0d", n_checks);

    // ---------------- load, words 1..16 ----------------
    accept(2'd0, {LB3, LB2, LB1, LB0}, 1'b1);
    #2;
    check("ld_addr_T0", bus_if.ga_addr, 32'd0);
    for (int t = 1; t <= 4; t++) begin
      tick();
      bus_if.ga_rdy = 1'b0;
      #2;
      check("ld_addr_send", bus_if.ga_addr, IDLE_ADDR);
      check("ld_no_rsp",    bus_if.rsp_valid, 1'b0);
      case (t)
        1: check("ld_beat0", bus_if.ga_data_in, LB0);
        2: check("ld_beat1", bus_if.ga_data_in, LB1);
        3: check("ld_beat2", bus_if.ga_data_in, LB2);
        default: check("ld_beat3", bus_if.ga_data_in, LB3);
      endcase
    end
    tick();                                   // T5 COMMIT
    #2;
    check("ld_commit_addr", bus_if.ga_addr, IDLE_ADDR);
    check("ld_commit_data", bus_if.ga_data_in, '0);
    check("ld_commit_done", bus_if.done, 1'b0);
    tick();                                   // T6
    bus_if.ga_rdy = 1'b1;
    #2;
    check("ld_done_T6",   bus_if.done, 1'b1);
    check("ld_idle_T6",   bus_if.cmd_ready, 1'b1);
    check("ld_no_rsp_T6", bus_if.rsp_valid, 1'b0);
    $display("txn load: checks so far %0d", n_checks);

    // ---------------- vertex with chained read ----------------
    tick();
    accept(2'd1, {VB3, VB2, VB1, VB0}, 1'b1);
    #2;
    check("vx_addr_T0", bus_if.ga_addr, 32'd1);
    for (int t = 1; t <= 3; t++) begin
      tick();
      bus_if.ga_rdy = 1'b0;
      #2;
      check("vx_addr_send", bus_if.ga_addr, IDLE_ADDR);
    end
    tick();                                   // T4
    #2;
    check("vx_rslt_addr_T4", bus_if.ga_addr, 32'd2);
    check("vx_beat3",        bus_if.ga_data_in, VB3);
    for (int t = 5; t <= 8; t++) begin
      tick();
      case (t)
        5: bus_if.ga_data_out = RA;
        6: bus_if.ga_data_out = RB;
        7: bus_if.ga_data_out = RC;
        default: bus_if.ga_data_out = RD;
      endcase
      #2;
      check("vx_no_rsp_in_read", bus_if.rsp_valid, 1'b0);
    end
    for (int t = 9; t <= 11; t++) begin
      tick();
      bus_if.ga_rdy      = 1'b1;
      bus_if.ga_data_out = JUNK;
      if (t == 11) begin
        // Take the response and offer a reserved command in the same cycle.
        bus_if.rsp_ready = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 2'd3;
      end
      #2;
      check("vx_rsp_valid_held", bus_if.rsp_valid, 1'b1);
      check("vx_rsp_data",       bus_if.rsp_data, {RD, RC, RB, RA});
      check("vx_no_done_held",   bus_if.done, 1'b0);
      check("vx_busy_in_resp",   bus_if.cmd_ready, 1'b0);
    end
    tick();                                   // T12
    bus_if.rsp_ready = 1'b0;
    #2;
    check("vx_rsp_dropped", bus_if.rsp_valid, 1'b0);
    check("vx_done",        bus_if.done, 1'b1);
    check("vx_idle",        bus_if.cmd_ready, 1'b1);
    check("rsvd_addr_acc",  bus_if.ga_addr, IDLE_ADDR);
    $display("txn vertex: checks so far %0d", n_checks);

    // ---------------- reserved op (accepted at T12) ----------------
    tick();                                   // T13
    bus_if.cmd_valid = 1'b0;
    #2;
    check("rsvd_err",      bus_if.err, 1'b1);
    check("rsvd_no_done",  bus_if.done, 1'b0);
    check("rsvd_addr",     bus_if.ga_addr, IDLE_ADDR);
    check("rsvd_idle",     bus_if.cmd_ready, 1'b1);
    tick();
    #2;
    check("rsvd_err_once", bus_if.err, 1'b0);
    check("rsvd_addr2",    bus_if.ga_addr, IDLE_ADDR);
    $display("txn reserved-op: checks so far %0d", n_checks);

    // ---------------- ga_rdy low for 5 cycles ----------------
    accept(2'd2, '0, 1'b0);
    for (int t = 0; t <= 4; t++) begin
      #2;
      check("wait_addr_idle", bus_if.ga_addr, IDLE_ADDR);
      tick();
    end
    bus_if.ga_rdy = 1'b1;                     // T5
    #2;
    check("wait_addr_on_rdy", bus_if.ga_addr, 32'd2);
    for (int t = 6; t <= 9; t++) begin
      tick();
      bus_if.ga_rdy = 1'b0;
      case (t)
        6: bus_if.ga_data_out = E0;
        7: bus_if.ga_data_out = E1;
        8: bus_if.ga_data_out = E2;
        default: bus_if.ga_data_out = E3;
      endcase
      #2;
      check("wait_addr_read", bus_if.ga_addr, IDLE_ADDR);
    end
    tick();                                   // T10
    bus_if.rsp_ready = 1'b1;
    #2;
    check("wait_rsp_valid", bus_if.rsp_valid, 1'b1);
    check("wait_rsp_data",  bus_if.rsp_data, {E3, E2, E1, E0});
    tick();
    bus_if.rsp_ready = 1'b0;
    bus_if.ga_rdy    = 1'b1;
    #2;
    check("wait_done", bus_if.done, 1'b1);
    $display("txn delayed-rdy read: checks so far %0d", n_checks);

    // ---------------- protocol error in SEND beat 2 ----------------
    tick();
    accept(2'd0, {LB3, LB2, LB1, LB0}, 1'b1);
    tick();                                   // T1 beat0
    bus_if.ga_rdy = 1'b0;
    tick();                                   // T2 beat1
    tick();                                   // T3 beat2
    bus_if.ga_rdy = 1'b1;
    #2;
    check("perr_beat2_data", bus_if.ga_data_in, LB2);
    tick();                                   // T4
    #2;
    check("perr_err",     bus_if.err, 1'b1);
    check("perr_idle",    bus_if.cmd_ready, 1'b1);
    check("perr_no_done", bus_if.done, 1'b0);
    check("perr_no_rsp",  bus_if.rsp_valid, 1'b0);
    check("perr_addr",    bus_if.ga_addr, IDLE_ADDR);
    tick();
    #2;
    check("perr_err_once", bus_if.err, 1'b0);
    check("perr_no_done2", bus_if.done, 1'b0);
    $display("txn protocol-error: checks so far %0d", n_checks);

    // ---------------- reset during READ beat 1 ----------------
    accept(2'd2, '0, 1'b1);
    tick();                                   // T1 READ beat0
    bus_if.ga_rdy      = 1'b0;
    bus_if.ga_data_out = JUNK;
    tick();                                   // T2 READ beat1
    rst = 1'b1;
    tick();                                   // T3
    rst           = 1'b0;
    bus_if.ga_rdy = 1'b1;
    #2;
    check_reset_outputs("midrst");
    tick();
    #2;
    check("midrst_no_done", bus_if.done, 1'b0);
    check("midrst_no_err",  bus_if.err, 1'b0);
    check("midrst_no_rsp",  bus_if.rsp_valid, 1'b0);
    $display("txn reset-mid-read: checks so far %0d", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
